// File: rtl/pb_value_capture_if.sv
// Button/switch inputs and captured-value outputs of pb_value_capture.
// The master drives buttons and switches; the slave (the capture block) drives results.
interface pb_value_capture_if;
  logic [3:0]  pb;
  logic [2:0]  y;
  logic [11:0] vals;
  logic [3:0]  loaded;
  logic        all_loaded;
  logic [1:0]  min_idx;
  logic [2:0]  min_val;
  logic        update;

  modport master (
    output pb, y,
    input  vals, loaded, all_loaded, min_idx, min_val, update
  );

  modport slave (
    input  pb, y,
    output vals, loaded, all_loaded, min_idx, min_val, update
  );
endinterface

// File: rtl/pb_value_capture.sv
// Syncs/debounces 4 buttons; each press captures the switch value into its slot, then tracks the minimum.
// Optional LOCK_AFTER_ALL_EN: once every slot is loaded, further presses are ignored until reset.
module pb_value_capture #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  pb_value_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       pb_m_q, pb_m_d, pb_s_q, pb_s_d;
  logic [2:0]       y_m_q, y_m_d, y_s_q, y_s_d;
  logic [3:0]       st_q, st_d, st_dly_q, st_dly_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press_q, press_d;
  logic [3:0]       cap_en;
  logic [2:0]       slot_q [4];
  logic [2:0]       slot_d [4];
  logic [3:0]       loaded_q, loaded_d;
  logic             cap_q, cap_d;
  logic [1:0]       min_idx_q, min_idx_d;
  logic [2:0]       min_val_q, min_val_d;
  logic             all_loaded_q, all_loaded_d;
  logic             update_q, update_d;

  always_comb begin
    pb_m_d   = bus.pb;
    pb_s_d   = pb_m_q;
    y_m_d    = bus.y;
    y_s_d    = y_m_q;
    st_d     = st_q;
    st_dly_d = st_q;
    press_d  = st_q & ~st_dly_q;

    // A level must differ from the stable state for DEBOUNCE_CYCLES consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (pb_s_q[i] != st_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          st_d[i] = pb_s_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

`ifdef LOCK_AFTER_ALL_EN
    cap_en = (&loaded_q) ? 4'b0000 : press_q;
`else
    cap_en = press_q;
`endif

    slot_d   = slot_q;
    loaded_d = loaded_q | cap_en;
    cap_d    = |cap_en;
    for (int i = 0; i < 4; i++) begin
      if (cap_en[i]) begin
        slot_d[i] = y_s_q;
      end
    end

    // Strict less-than keeps the lowest index on ties.
    min_idx_d = 2'd0;
    min_val_d = slot_q[0];
    for (int i = 1; i < 4; i++) begin
      if (slot_q[i] < min_val_d) begin
        min_idx_d = 2'(i);
        min_val_d = slot_q[i];
      end
    end

    all_loaded_d = &loaded_q;
    update_d     = cap_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_m_q       <= '0;
      pb_s_q       <= '0;
      y_m_q        <= '0;
      y_s_q        <= '0;
      st_q         <= '0;
      st_dly_q     <= '0;
      press_q      <= '0;
      loaded_q     <= '0;
      cap_q        <= 1'b0;
      min_idx_q    <= '0;
      min_val_q    <= '0;
      all_loaded_q <= 1'b0;
      update_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        slot_q[i] <= '0;
      end
    end else begin
      pb_m_q       <= pb_m_d;
      pb_s_q       <= pb_s_d;
      y_m_q        <= y_m_d;
      y_s_q        <= y_s_d;
      st_q         <= st_d;
      st_dly_q     <= st_dly_d;
      press_q      <= press_d;
      loaded_q     <= loaded_d;
      cap_q        <= cap_d;
      min_idx_q    <= min_idx_d;
      min_val_q    <= min_val_d;
      all_loaded_q <= all_loaded_d;
      update_q     <= update_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= cnt_d[i];
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign bus.vals       = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
  assign bus.loaded     = loaded_q;
  assign bus.all_loaded = all_loaded_q;
  assign bus.min_idx    = min_idx_q;
  assign bus.min_val    = min_val_q;
  assign bus.update     = update_q;

endmodule
